// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producers, the stream mux and one consumer.
// master = environment side, slave = mux side.
interface stream_mux_rr_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_last;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SEL_W-1:0]     sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_last;
  logic [SEL_W-1:0]     out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic                 locked;

  modport master (
    output in_data, in_valid, in_last,
    output mode, sel, out_ready,
    input  in_ready, out_data, out_last,
    input  out_ch, out_valid, locked
  );

  modport slave (
    input  in_data, in_valid, in_last,
    input  mode, sel, out_ready,
    output in_ready, out_data, out_last,
    output out_ch, out_valid, locked
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel stream mux: fixed or round-robin select, packet lock,
// single registered output slot.
module stream_mux_rr #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_mux_rr_if.slave  bus
);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] lock_ch_q;
  logic [SEL_W-1:0] lock_ch_d;
  logic [SEL_W-1:0] rr_ptr_q;

  logic [WIDTH-1:0] data_q;
  logic             last_q;
  logic [SEL_W-1:0] ch_q;
  logic             valid_q;

  logic             load_en;
  logic [SEL_W-1:0] g;
  logic             grant_valid;
  logic [SEL_W-1:0] rr_g;
  logic             rr_hit;
  logic             fix_hit;
  logic             lock_hit;
  logic [NCH-1:0]   ready;
  logic             xfer;
  logic [WIDTH-1:0] xfer_data;
  logic             xfer_last;

  assign load_en = !valid_q || bus.out_ready;

  // Upper group (above rr_ptr) overrides lower group: wrap search order
  always_comb begin : rr_search
    rr_g   = '0;
    rr_hit = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.in_valid[i] && SEL_W'(i) <= rr_ptr_q) begin
        rr_g   = SEL_W'(i);
        rr_hit = 1'b1;
      end
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.in_valid[i] && SEL_W'(i) > rr_ptr_q) begin
        rr_g   = SEL_W'(i);
        rr_hit = 1'b1;
      end
    end
  end

  always_comb begin : ch_hits
    fix_hit  = 1'b0;
    lock_hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (SEL_W'(i) == bus.sel)
        fix_hit = bus.in_valid[i];
      if (SEL_W'(i) == lock_ch_q)
        lock_hit = bus.in_valid[i];
    end
  end

  always_comb begin : grant
    g           = '0;
    grant_valid = 1'b0;
    unique case (1'b1)
      (state_q == LOCK): begin
        g           = lock_ch_q;
        grant_valid = lock_hit;
      end
      (state_q == IDLE && bus.mode): begin
        g           = rr_g;
        grant_valid = rr_hit;
      end
      (state_q == IDLE && !bus.mode): begin
        g           = bus.sel;
        grant_valid = fix_hit;
      end
    endcase
  end

  always_comb begin : steer
    ready     = '0;
    xfer_data = '0;
    xfer_last = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (SEL_W'(i) == g) begin
        xfer_data = bus.in_data[i*WIDTH +: WIDTH];
        xfer_last = bus.in_last[i];
        ready[i]  = rst_n && load_en && grant_valid;
      end
    end
  end

  assign bus.in_ready = ready;
  assign xfer         = |(ready & bus.in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  always_comb begin : lock_fsm
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    unique case (state_q)
      IDLE: begin
        if (xfer && !xfer_last) begin
          state_d   = LOCK;
          lock_ch_d = g;
        end
      end
      LOCK: begin
        if (xfer && xfer_last)
          state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr_q <= SEL_W'(NCH - 1);
    else if (xfer && bus.mode)
      rr_ptr_q <= g;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ch_q    <= '0;
    end else if (load_en) begin
      valid_q <= xfer;
      if (xfer) begin
        data_q <= xfer_data;
        last_q <= xfer_last;
        ch_q   <= g;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;
  assign bus.locked    = (state_q == LOCK);

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: queue-fed sources, behavioural model,
// per-cycle compare plus directed literal checks.
module tb_stream_mux_rr;
  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SEL_W = 3;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_rr_if #(
    .WIDTH(WIDTH), .NCH(NCH), .SEL_W(SEL_W)
  ) bus ();

  stream_mux_rr #(
    .WIDTH(WIDTH), .NCH(NCH), .SEL_W(SEL_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  beat_t q[NCH][$];

  int tests = 0;
  int fails = 0;

  // model state: what the output slot and arbiter must hold
  bit               m_ov     = 1'b0;
  logic [WIDTH-1:0] m_od     = '0;
  bit               m_ol     = 1'b0;
  int               m_och    = 0;
  bit               m_locked = 1'b0;
  int               m_lockch = 0;
  int               m_ptr    = NCH - 1;

  task automatic chk(string name, logic [63:0] got,
                     logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  function automatic void model_grant(output int g,
                                      output bit gv);
    g  = 0;
    gv = 1'b0;
    if (rst_n !== 1'b1) return;
    if (m_ov && !bus.out_ready) return;
    if (m_locked) begin
      g  = m_lockch;
      gv = bus.in_valid[g];
    end else if (!bus.mode) begin
      g  = int'(bus.sel);
      gv = (g < NCH) ? bus.in_valid[g] : 1'b0;
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (bus.in_valid[c]) begin
          g  = c;
          gv = 1'b1;
          break;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    bit gv;
    if (!rst_n) begin
      m_ov     = 1'b0;
      m_od     = '0;
      m_ol     = 1'b0;
      m_och    = 0;
      m_locked = 1'b0;
      m_lockch = 0;
      m_ptr    = NCH - 1;
    end else begin
      model_grant(g, gv);
      if (gv) begin
        m_ov  = 1'b1;
        m_od  = bus.in_data[g*WIDTH +: WIDTH];
        m_ol  = bus.in_last[g];
        m_och = g;
        if (bus.mode) m_ptr = g;
        if (!m_locked && !m_ol) begin
          m_locked = 1'b1;
          m_lockch = g;
        end else if (m_locked && m_ol) begin
          m_locked = 1'b0;
        end
        if (q[g].size() > 0) void'(q[g].pop_front());
      end else if (!m_ov || bus.out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    bit gv;
    logic [NCH-1:0] er;
    model_grant(g, gv);
    er = gv ? (NCH'(1) << g) : '0;
    chk("in_ready", 64'(bus.in_ready), 64'(er));
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk("out_data", 64'(bus.out_data), 64'(m_od));
    chk("out_last", 64'(bus.out_last), 64'(m_ol));
    chk("out_ch", 64'(bus.out_ch), 64'(m_och));
    chk("locked", 64'(bus.locked), 64'(m_locked));
  end

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      if (q[i].size() > 0) begin
        bus.in_valid[i] = 1'b1;
        bus.in_data[i*WIDTH +: WIDTH] = q[i][0].d;
        bus.in_last[i] = q[i][0].l;
      end else begin
        bus.in_valid[i] = 1'b0;
        bus.in_data[i*WIDTH +: WIDTH] = '0;
        bus.in_last[i] = 1'b0;
      end
    end
  endtask

  task automatic push(int ch, logic [WIDTH-1:0] d, bit l);
    beat_t b;
    b.d = d;
    b.l = l;
    q[ch].push_back(b);
  endtask

  task automatic clr();
    for (int i = 0; i < NCH; i++) q[i].delete();
  endtask

  task automatic top_up();
    for (int i = 0; i < NCH; i++)
      if (q[i].size() == 0) push(i, $urandom, 1'b1);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.mode      = 1'b1;
    bus.sel       = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) push(i, 32'h100 + i, 1'b1);
    drive();

    // reset with traffic present
    @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_locked", 64'(bus.locked), 64'd0);
    repeat (2) @(posedge clk);

    // release: round-robin from channel 0, one beat per cycle
    edge1();
    rst_n = 1'b1;
    top_up();
    drive();
    for (int k = 0; k < 6; k++) begin
      edge1();
      top_up();
      drive();
      @(negedge clk);
      chk("rr_seq", 64'(bus.out_ch), 64'(k % NCH));
      chk("rr_valid", 64'(bus.out_valid), 64'd1);
      if (k == 0)
        chk("rr_first", 64'(bus.out_data), 64'h100);
    end

    // fixed select
    edge1(); clr(); drive();
    edge1(); drive();
    bus.mode = 1'b0;
    bus.sel  = 3'd2;
    push(2, 32'hDEADBEEF, 1'b1);
    push(0, 32'h11, 1'b1);
    push(1, 32'h22, 1'b1);
    drive();
    edge1(); drive();
    @(negedge clk);
    chk("fix_data", 64'(bus.out_data), 64'hDEADBEEF);
    chk("fix_ch", 64'(bus.out_ch), 64'd2);
    edge1();
    bus.sel = 3'd5;
    drive();
    @(negedge clk);
    chk("fix_oob_ready", 64'(bus.in_ready), 64'd0);
    edge1(); drive();
    @(negedge clk);
    chk("fix_oob_valid", 64'(bus.out_valid), 64'd0);

    // packet lock: ch1 three beats while ch0/ch2 wait
    edge1(); clr();
    bus.mode = 1'b1;
    push(0, 32'hA0, 1'b1);
    drive();
    edge1(); drive();
    push(1, 32'hB1, 1'b0);
    push(1, 32'hB2, 1'b0);
    push(1, 32'hB3, 1'b1);
    push(0, 32'hA1, 1'b1);
    push(2, 32'hC1, 1'b1);
    drive();
    edge1();
    bus.mode = 1'b0;
    bus.sel  = 3'd0;
    drive();
    @(negedge clk);
    chk("lk1_ch", 64'(bus.out_ch), 64'd1);
    chk("lk1_locked", 64'(bus.locked), 64'd1);
    edge1();
    bus.mode = 1'b1;
    bus.sel  = 3'd2;
    drive();
    @(negedge clk);
    chk("lk2_ch", 64'(bus.out_ch), 64'd1);
    chk("lk2_data", 64'(bus.out_data), 64'hB2);
    chk("lk2_locked", 64'(bus.locked), 64'd1);
    edge1(); drive();
    @(negedge clk);
    chk("lk3_ch", 64'(bus.out_ch), 64'd1);
    chk("lk3_last", 64'(bus.out_last), 64'd1);
    chk("lk3_locked", 64'(bus.locked), 64'd0);
    edge1(); drive();
    @(negedge clk);
    chk("lk_next_ch", 64'(bus.out_ch), 64'd2);

    // backpressure: hold slot for six cycles
    edge1(); clr(); drive();
    edge1(); drive();
    push(2, 32'hE0, 1'b1);
    push(2, 32'hE1, 1'b1);
    push(2, 32'hE2, 1'b1);
    drive();
    edge1();
    bus.out_ready = 1'b0;
    drive();
    @(negedge clk);
    chk("bp_first", 64'(bus.out_data), 64'hE0);
    repeat (5) begin
      edge1(); drive();
      @(negedge clk);
      chk("bp_hold", 64'(bus.out_data), 64'hE0);
      chk("bp_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
    end
    edge1();
    bus.out_ready = 1'b1;
    drive();
    edge1(); drive();
    @(negedge clk);
    chk("bp_e1", 64'(bus.out_data), 64'hE1);
    edge1(); drive();
    @(negedge clk);
    chk("bp_e2", 64'(bus.out_data), 64'hE2);

    // reset in the middle of a 4-beat packet on ch3
    edge1(); clr(); drive();
    edge1(); drive();
    push(3, 32'hF0, 1'b0);
    push(3, 32'hF1, 1'b0);
    push(3, 32'hF2, 1'b0);
    push(3, 32'hF3, 1'b1);
    drive();
    edge1(); drive();
    @(negedge clk);
    chk("mr1_ch", 64'(bus.out_ch), 64'd3);
    chk("mr1_locked", 64'(bus.locked), 64'd1);
    edge1(); drive();
    @(negedge clk);
    chk("mr2_data", 64'(bus.out_data), 64'hF1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_locked", 64'(bus.locked), 64'd0);
    chk("mr_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_ready", 64'(bus.in_ready), 64'd0);
    clr();
    push(0, 32'h70, 1'b1);
    push(3, 32'h73, 1'b1);
    drive();
    edge1();
    rst_n = 1'b1;
    drive();
    edge1(); drive();
    @(negedge clk);
    chk("mr_restart0", 64'(bus.out_ch), 64'd0);
    edge1(); drive();
    @(negedge clk);
    chk("mr_restart3", 64'(bus.out_ch), 64'd3);

    // randomized traffic, modes, selects and backpressure
    repeat (3000) begin
      edge1();
      if ($urandom_range(0, 49) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 19) == 0)
        bus.sel = SEL_W'($urandom_range(0, 4));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NCH; i++) begin
        if (q[i].size() < 3 && $urandom_range(0, 3) == 0) begin
          int n;
          n = $urandom_range(1, 4);
          for (int b = 0; b < n; b++)
            push(i, $urandom, (b == n - 1));
        end
      end
      drive();
    end

    edge1();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
